// File: rtl/pacman_display_timing_pkg.sv
// Shared VGA timing constants, game dimensions and the sync bus layout
// used by the pacman display timing source.
package pacman_display_timing_pkg;

  // 640x480@60 raster
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Default placement of the game window inside the visible area
  localparam int VGA_X_OFF    = 208;
  localparam int VGA_Y_OFF    = 96;

  // Game-space dimensions
  localparam int PAC_GAME_W   = 224;
  localparam int PAC_GAME_H   = 288;

  localparam int DEF_PIPE_LAT = 2;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Signals that travel together through the alignment delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/pacman_display_timing_sync_delay.sv
// Fixed-depth shift register with asynchronous active-low reset to RST_VAL.
// Keeps syncs and display-enable in step with the game's RGB pipeline.
module sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stages;

    // Shift din one stage per clock; stage DEPTH-1 is the output
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stages <= {DEPTH{RST_VAL}};
      end else begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/pacman_display_timing.sv
// VGA raster generator feeding pacman_game: game-space coordinates and
// strobes out, game RGB back in, blanked and aligned with delayed syncs.
module pacman_display_timing
  import pacman_display_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int GAME_W   = PAC_GAME_W,
  parameter int GAME_H   = PAC_GAME_H,
  parameter int SCALE    = 1,
  parameter int X_OFF    = VGA_X_OFF,
  parameter int Y_OFF    = VGA_Y_OFF,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst_n,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic                      display_enabled,
  input  logic [11:0]               rgb_in,
  output logic [3:0]                vga_r,
  output logic [3:0]                vga_g,
  output logic [3:0]                vga_b,
  output logic                      vga_hs,
  output logic                      vga_vs
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SXW     = $clog2(GAME_W);
  localparam int SYW     = $clog2(GAME_H);
  localparam int SUBW    = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0]   H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   X_START  = HW'(X_OFF);
  localparam logic [HW-1:0]   X_END    = HW'(X_OFF + GAME_W * SCALE);
  localparam logic [HW-1:0]   HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]   HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]   V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   Y_START  = VW'(Y_OFF);
  localparam logic [VW-1:0]   Y_END    = VW'(Y_OFF + GAME_H * SCALE);
  localparam logic [VW-1:0]   VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]   VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SCALE - 1);

  if (SCALE < 1) begin : g_bad_scale
    $error("SCALE must be at least 1");
  end
  if (X_OFF + GAME_W * SCALE > H_ACTIVE) begin : g_bad_x
    $error("game window extends past H_ACTIVE");
  end
  if (Y_OFF + GAME_H * SCALE > V_ACTIVE) begin : g_bad_y
    $error("game window extends past V_ACTIVE");
  end

  logic [HW-1:0]   hcnt, h_nxt;
  logic [VW-1:0]   vcnt, v_nxt;
  logic            line_end, in_win;
  logic [SUBW-1:0] sub_x, sub_y;
  // Game coordinate trackers; wide enough to run past the window harmlessly
  logic [HW-1:0]   gx;
  logic [VW-1:0]   gy;
  logic            hs_raw, vs_raw;
  sync_bus_t       raw_bus, dly_bus;

  // Next raster position and window membership of the current position
  always_comb begin
    line_end = (hcnt == H_LAST);
    h_nxt    = line_end ? '0 : hcnt + HW'(1);
    v_nxt    = vcnt;
    if (line_end) v_nxt = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    in_win   = (hcnt >= X_START) && (hcnt < X_END) &&
               (vcnt >= Y_START) && (vcnt < Y_END);
  end

  // Raster counters
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_nxt;
      vcnt <= v_nxt;
    end
  end

  // Horizontal game coordinate: cleared entering the window column, then
  // advanced on each sub-pixel wrap so no divider is needed
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x <= '0;
      gx    <= '0;
    end else if (h_nxt == X_START) begin
      sub_x <= '0;
      gx    <= '0;
    end else if (sub_x == SUB_LAST) begin
      sub_x <= '0;
      gx    <= gx + HW'(1);
    end else begin
      sub_x <= sub_x + SUBW'(1);
    end
  end

  // Vertical game coordinate: same scheme, stepped once per line
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_y <= '0;
      gy    <= '0;
    end else if (line_end) begin
      if (v_nxt == Y_START) begin
        sub_y <= '0;
        gy    <= '0;
      end else if (sub_y == SUB_LAST) begin
        sub_y <= '0;
        gy    <= gy + VW'(1);
      end else begin
        sub_y <= sub_y + SUBW'(1);
      end
    end
  end

  // Game-facing outputs and raw syncs, one cycle behind the counters
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      sx              <= '0;
      sy              <= '0;
      display_enabled <= 1'b0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
      hs_raw          <= 1'b1;
      vs_raw          <= 1'b1;
    end else begin
      sx              <= in_win ? SXW'(gx) : '0;
      sy              <= in_win ? SYW'(gy) : '0;
      display_enabled <= in_win;
      game_pix_stb    <= in_win && (sub_x == '0);
      frame_stb       <= (hcnt == X_START) && (vcnt == Y_START);
      hs_raw          <= !((hcnt >= HS_START) && (hcnt < HS_END));
      vs_raw          <= !((vcnt >= VS_START) && (vcnt < VS_END));
    end
  end

  assign raw_bus = '{hs: hs_raw, vs: vs_raw, de: display_enabled};

  sync_delay #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   ($bits(sync_bus_t)),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (vga_pix_clk),
    .rst_n (rst_n),
    .din   (raw_bus),
    .dout  (dly_bus)
  );

  // Pin register: game colour only where the delayed window is active
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= dly_bus.de ? rgb_in[11:8] : 4'h0;
      vga_g  <= dly_bus.de ? rgb_in[7:4]  : 4'h0;
      vga_b  <= dly_bus.de ? rgb_in[3:0]  : 4'h0;
      vga_hs <= dly_bus.hs;
      vga_vs <= dly_bus.vs;
    end
  end

endmodule

// File: tb/tb_pacman_display_timing.sv
// Bench for pacman_display_timing: two shrunken rasters (SCALE=1 and SCALE=2)
// for frame-level behaviour plus one default 640x480 instance for line timing.
module tb_pacman_display_timing;

  localparam int L       = 2;
  localparam int S_FRAME = 56 * 37;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   fff = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; int sx; int sy;
    bit de; bit stb; bit fs; bit hs; bit vs;
  } exp_t;

  function automatic exp_t calc(input int h, input int v, input int xo, input int yo,
                                input int gw, input int gh, input int sc,
                                input int hss, input int hse, input int vss, input int vse);
    exp_t e;
    bit   w;
    w     = (h >= xo) && (h < xo + gw * sc) && (v >= yo) && (v < yo + gh * sc);
    e.h   = h;
    e.v   = v;
    e.de  = w;
    e.sx  = w ? (h - xo) / sc : 0;
    e.sy  = w ? (v - yo) / sc : 0;
    e.stb = w && ((h - xo) % sc == 0);
    e.fs  = (h == xo) && (v == yo);
    e.hs  = !((h >= hss) && (h < hse));
    e.vs  = !((v >= vss) && (v < vse));
    return e;
  endfunction

  function automatic logic [11:0] pix(input int x, input int y, input bit f);
    logic [3:0] x4, y4;
    x4 = x[3:0];
    y4 = y[3:0];
    return f ? 12'hFFF : {x4, y4, x4 ^ y4};
  endfunction

  // ---------------- DUT a: 56x37 raster, 16x20 game at (10,5), SCALE=1
  logic [3:0]  a_sx;
  logic [4:0]  a_sy;
  logic        a_stb, a_fs, a_de, a_hs, a_vs;
  logic [11:0] a_pin, a_rgb_in, a_g1;

  pacman_display_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .GAME_W(16), .GAME_H(20), .SCALE(1), .X_OFF(10), .Y_OFF(5), .PIPE_LAT(L)
  ) dut_a (
    .vga_pix_clk(clk), .rst_n(rst_n), .sx(a_sx), .sy(a_sy),
    .game_pix_stb(a_stb), .frame_stb(a_fs), .display_enabled(a_de),
    .rgb_in(a_rgb_in), .vga_r(a_pin[11:8]), .vga_g(a_pin[7:4]), .vga_b(a_pin[3:0]),
    .vga_hs(a_hs), .vga_vs(a_vs)
  );

  // ---------------- DUT b: same raster, 12x10 game at (8,4), SCALE=2
  logic [3:0]  b_sx;
  logic [3:0]  b_sy;
  logic        b_stb, b_fs, b_de, b_hs, b_vs;
  logic [11:0] b_pin, b_rgb_in, b_g1;

  pacman_display_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .GAME_W(12), .GAME_H(10), .SCALE(2), .X_OFF(8), .Y_OFF(4), .PIPE_LAT(L)
  ) dut_b (
    .vga_pix_clk(clk), .rst_n(rst_n), .sx(b_sx), .sy(b_sy),
    .game_pix_stb(b_stb), .frame_stb(b_fs), .display_enabled(b_de),
    .rgb_in(b_rgb_in), .vga_r(b_pin[11:8]), .vga_g(b_pin[7:4]), .vga_b(b_pin[3:0]),
    .vga_hs(b_hs), .vga_vs(b_vs)
  );

  // ---------------- DUT c: default 640x480 timing
  logic [7:0]  c_sx;
  logic [8:0]  c_sy;
  logic        c_stb, c_fs, c_de, c_hs, c_vs;
  logic [11:0] c_pin;
  logic [11:0] c_rgb_in = 12'hFFF;

  pacman_display_timing dut_c (
    .vga_pix_clk(clk), .rst_n(rst_n), .sx(c_sx), .sy(c_sy),
    .game_pix_stb(c_stb), .frame_stb(c_fs), .display_enabled(c_de),
    .rgb_in(c_rgb_in), .vga_r(c_pin[11:8]), .vga_g(c_pin[7:4]), .vga_b(c_pin[3:0]),
    .vga_hs(c_hs), .vga_vs(c_vs)
  );

  // Game stand-in: colour derived from sx/sy, returned L cycles later
  always @(posedge clk) begin
    a_g1     <= pix(int'(a_sx), int'(a_sy), fff);
    a_rgb_in <= a_g1;
    b_g1     <= pix(int'(b_sx), int'(b_sy), fff);
    b_rgb_in <= b_g1;
  end

  // Scoreboards: each edge pushes the expectation for the raster position
  // the DUT counters hold. q[$] is what the game outputs show after this
  // edge, q[0] (once L+2 deep) is what the pins show.
  exp_t a_q[$], b_q[$], c_q[$];
  int   a_h, a_v, b_h, b_v, c_h, c_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q.delete(); b_q.delete(); c_q.delete();
      a_h <= 0; a_v <= 0; b_h <= 0; b_v <= 0; c_h <= 0; c_v <= 0;
    end else begin
      if (a_q.size() == L + 2) void'(a_q.pop_front());
      if (b_q.size() == L + 2) void'(b_q.pop_front());
      if (c_q.size() == L + 2) void'(c_q.pop_front());
      a_q.push_back(calc(a_h, a_v, 10, 5, 16, 20, 1, 44, 50, 32, 34));
      b_q.push_back(calc(b_h, b_v, 8, 4, 12, 10, 2, 44, 50, 32, 34));
      c_q.push_back(calc(c_h, c_v, 208, 96, 224, 288, 1, 656, 752, 490, 492));
      a_h <= (a_h == 55) ? 0 : a_h + 1;
      a_v <= (a_h == 55) ? ((a_v == 36) ? 0 : a_v + 1) : a_v;
      b_h <= (b_h == 55) ? 0 : b_h + 1;
      b_v <= (b_h == 55) ? ((b_v == 36) ? 0 : b_v + 1) : b_v;
      c_h <= (c_h == 799) ? 0 : c_h + 1;
      c_v <= (c_h == 799) ? ((c_v == 524) ? 0 : c_v + 1) : c_v;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int found;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_sx, a_sy, a_stb, a_fs, a_de, a_pin, a_hs, a_vs} !== {27'h0, 2'b11}) begin
      n_fail++; $display("FAIL reset_a got sx=%0d sy=%0d stb=%b fs=%b de=%b pin=%h hs=%b vs=%b want zeros, hs=vs=1",
                         a_sx, a_sy, a_stb, a_fs, a_de, a_pin, a_hs, a_vs);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (870) @(posedge clk);   // dut_a now at hcnt=30, vcnt=15
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_sx, a_sy, a_stb, a_fs, a_de, a_pin, a_hs, a_vs} !== {27'h0, 2'b11}) begin
      n_fail++; $display("FAIL midreset_a got sx=%0d sy=%0d stb=%b fs=%b de=%b pin=%h hs=%b vs=%b want zeros, hs=vs=1",
                         a_sx, a_sy, a_stb, a_fs, a_de, a_pin, a_hs, a_vs);
    end
    n_chk++;
    if ({b_sx, b_sy, b_stb, b_fs, b_de, b_pin, b_hs, b_vs} !== {26'h0, 2'b11}) begin
      n_fail++; $display("FAIL midreset_b got sx=%0d sy=%0d de=%b pin=%h hs=%b vs=%b want zeros, hs=vs=1",
                         b_sx, b_sy, b_de, b_pin, b_hs, b_vs);
    end
    n_chk++;
    if ({c_sx, c_sy, c_stb, c_fs, c_de, c_pin, c_hs, c_vs} !== {32'h0, 2'b11}) begin
      n_fail++; $display("FAIL midreset_c got sx=%0d sy=%0d de=%b pin=%h hs=%b vs=%b want zeros, hs=vs=1",
                         c_sx, c_sy, c_de, c_pin, c_hs, c_vs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    found = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (!c_hs) begin found = c; break; end
    end
    n_chk++;
    if (found != 656 + L + 2) begin
      n_fail++; $display("FAIL first_hs_after_reset got %0d cycles want %0d", found, 656 + L + 2);
    end
  endtask

  task automatic test_line_timing();
    exp_t e, p;
    int   falls = 0, last_fall = -1;
    bit   prev = 1'b1;
    apply_reset();
    for (int c = 1; c <= 3200; c++) begin
      @(negedge clk);
      e = c_q[$];
      n_chk++;
      if (int'(c_sx) !== e.sx || int'(c_sy) !== e.sy || c_de !== e.de || c_fs !== e.fs) begin
        n_fail++; $display("FAIL c_stage cyc=%0d got sx=%0d sy=%0d de=%b fs=%b want %0d %0d %b %b",
                           c, c_sx, c_sy, c_de, c_fs, e.sx, e.sy, e.de, e.fs);
      end
      if (c_q.size() == L + 2) begin
        p = c_q[0];
        n_chk++;
        if (c_hs !== p.hs || c_vs !== p.vs || c_pin !== (p.de ? 12'hFFF : 12'h000)) begin
          n_fail++; $display("FAIL c_pins cyc=%0d got hs=%b vs=%b pin=%h want hs=%b vs=%b de=%b",
                             c, c_hs, c_vs, c_pin, p.hs, p.vs, p.de);
        end
      end
      if (prev && !c_hs) begin
        falls++;
        n_chk++;
        if (last_fall < 0 ? (c != 660) : (c - last_fall != 800)) begin
          n_fail++; $display("FAIL hs_period cyc=%0d got gap %0d want 800 (first at 660)", c, c - last_fall);
        end
        last_fall = c;
      end
      if (!prev && c_hs) begin
        n_chk++;
        if (c - last_fall != 96) begin
          n_fail++; $display("FAIL hs_width got %0d want 96", c - last_fall);
        end
      end
      prev = c_hs;
    end
    n_chk++;
    if (falls != 4) begin
      n_fail++; $display("FAIL hs_count got %0d want 4", falls);
    end
  endtask

  task automatic test_window_a();
    exp_t e, p;
    int   fs_cnt = 0, last_fs = -1, vs_low = 0;
    apply_reset();
    for (int c = 1; c <= 2 * S_FRAME + 10; c++) begin
      @(negedge clk);
      e = a_q[$];
      n_chk++;
      if (int'(a_sx) !== e.sx || int'(a_sy) !== e.sy || a_de !== e.de || a_stb !== e.stb || a_fs !== e.fs) begin
        n_fail++; $display("FAIL a_stage cyc=%0d got sx=%0d sy=%0d de=%b stb=%b fs=%b want %0d %0d %b %b %b",
                           c, a_sx, a_sy, a_de, a_stb, a_fs, e.sx, e.sy, e.de, e.stb, e.fs);
      end
      if (a_q.size() == L + 2) begin
        p = a_q[0];
        n_chk++;
        if (a_pin !== (p.de ? pix(p.sx, p.sy, fff) : 12'h000) || a_hs !== p.hs || a_vs !== p.vs) begin
          n_fail++; $display("FAIL a_pins cyc=%0d got pin=%h hs=%b vs=%b want pin=%h hs=%b vs=%b",
                             c, a_pin, a_hs, a_vs, p.de ? pix(p.sx, p.sy, fff) : 12'h000, p.hs, p.vs);
        end
      end
      if (e.h == 25 && e.v == 24) begin
        n_chk++;
        if (a_sx !== 4'd15 || a_sy !== 5'd19 || a_de !== 1'b1) begin
          n_fail++; $display("FAIL a_last_pixel got sx=%0d sy=%0d de=%b want 15 19 1", a_sx, a_sy, a_de);
        end
      end
      if (e.h == 26 && e.v == 24) begin
        n_chk++;
        if (a_sx !== 4'd0 || a_de !== 1'b0) begin
          n_fail++; $display("FAIL a_past_window got sx=%0d de=%b want 0 0", a_sx, a_de);
        end
      end
      if (a_fs === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          n_chk++;
          if (c - last_fs != S_FRAME) begin
            n_fail++; $display("FAIL frame_period got %0d want %0d", c - last_fs, S_FRAME);
          end
        end
        last_fs = c;
      end
      if (a_vs === 1'b0) vs_low++;
    end
    n_chk++;
    if (fs_cnt != 2) begin
      n_fail++; $display("FAIL frame_stb_count got %0d want 2", fs_cnt);
    end
    n_chk++;
    if (vs_low != 2 * 2 * 56) begin
      n_fail++; $display("FAIL vs_low_cycles got %0d want %0d", vs_low, 2 * 2 * 56);
    end
  endtask

  task automatic test_scale2();
    exp_t e, p;
    int   stb_cnt = 0;
    apply_reset();
    for (int c = 1; c <= 2 * S_FRAME + 10; c++) begin
      @(negedge clk);
      e = b_q[$];
      n_chk++;
      if (int'(b_sx) !== e.sx || int'(b_sy) !== e.sy || b_de !== e.de || b_stb !== e.stb || b_fs !== e.fs) begin
        n_fail++; $display("FAIL b_stage cyc=%0d got sx=%0d sy=%0d de=%b stb=%b fs=%b want %0d %0d %b %b %b",
                           c, b_sx, b_sy, b_de, b_stb, b_fs, e.sx, e.sy, e.de, e.stb, e.fs);
      end
      if (b_q.size() == L + 2) begin
        p = b_q[0];
        n_chk++;
        if (b_pin !== (p.de ? pix(p.sx, p.sy, fff) : 12'h000) || b_hs !== p.hs || b_vs !== p.vs) begin
          n_fail++; $display("FAIL b_pins cyc=%0d got pin=%h hs=%b vs=%b want pin=%h hs=%b vs=%b",
                             c, b_pin, b_hs, b_vs, p.de ? pix(p.sx, p.sy, fff) : 12'h000, p.hs, p.vs);
        end
      end
      if (e.v == 5 && (e.h == 9 || e.h == 10)) begin
        n_chk++;
        if (int'(b_sx) != e.h - 9 || b_sy !== 4'd0 || b_stb !== (e.h == 10)) begin
          n_fail++; $display("FAIL b_sx_step h=%0d got sx=%0d sy=%0d stb=%b", e.h, b_sx, b_sy, b_stb);
        end
      end
      if (e.h == 31 && e.v == 23) begin
        n_chk++;
        if (b_sx !== 4'd11 || b_sy !== 4'd9 || b_de !== 1'b1) begin
          n_fail++; $display("FAIL b_last_pixel got sx=%0d sy=%0d de=%b want 11 9 1", b_sx, b_sy, b_de);
        end
      end
      if (b_stb === 1'b1) stb_cnt++;
    end
    n_chk++;
    if (stb_cnt != 2 * 12 * 20) begin
      n_fail++; $display("FAIL b_stb_count got %0d want %0d", stb_cnt, 2 * 12 * 20);
    end
  endtask

  task automatic test_blanking();
    exp_t pa, pb;
    int   a_cnt = 0, b_cnt = 0, a_first = -1, b_first = -1;
    fff = 1'b1;
    apply_reset();
    for (int c = 1; c <= S_FRAME; c++) begin
      @(negedge clk);
      if (a_q.size() == L + 2) begin
        pa = a_q[0];
        n_chk++;
        if (a_pin !== (pa.de ? 12'hFFF : 12'h000)) begin
          n_fail++; $display("FAIL a_blank cyc=%0d got %h want %h", c, a_pin, pa.de ? 12'hFFF : 12'h000);
        end
      end
      if (b_q.size() == L + 2) begin
        pb = b_q[0];
        n_chk++;
        if (b_pin !== (pb.de ? 12'hFFF : 12'h000)) begin
          n_fail++; $display("FAIL b_blank cyc=%0d got %h want %h", c, b_pin, pb.de ? 12'hFFF : 12'h000);
        end
      end
      if (a_pin === 12'hFFF) begin a_cnt++; if (a_first < 0) a_first = c; end
      if (b_pin === 12'hFFF) begin b_cnt++; if (b_first < 0) b_first = c; end
    end
    n_chk++;
    if (a_cnt != 16 * 20 || a_first != 5 * 56 + 10 + 1 + L + 1) begin
      n_fail++; $display("FAIL a_fff_window got %0d cycles first %0d want %0d first %0d",
                         a_cnt, a_first, 16 * 20, 5 * 56 + 10 + 1 + L + 1);
    end
    n_chk++;
    if (b_cnt != 24 * 20 || b_first != 4 * 56 + 8 + 1 + L + 1) begin
      n_fail++; $display("FAIL b_fff_window got %0d cycles first %0d want %0d first %0d",
                         b_cnt, b_first, 24 * 20, 4 * 56 + 8 + 1 + L + 1);
    end
    fff = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_window_a();
    test_scale2();
    test_blanking();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pacman_display_timing.md
Name: pacman_display_timing

Overview:
- Source end of the game pixel interface. Generates VGA raster timing from vga_pix_clk.
- Produces the game-space coordinates and strobes that pacman_game consumes: sx, sy, game_pix_stb, frame_stb, display_enabled.
- Takes pacman_game's RGB back, delays syncs to match its pipeline latency, blanks RGB outside the game window, and drives the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- GAME_W, 224, game width in game pixels
- GAME_H, 288, game height in game pixels
- SCALE, 1, physical pixels per game pixel (each axis, integer ≥1)
- X_OFF, 208, first physical column of game window
- Y_OFF, 96, first physical line of game window
- PIPE_LAT, 2, cycles from sx/sy output to valid rgb_in

Ports:
- vga_pix_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- sx  out  $clog2(GAME_W)  game x coordinate
- sy  out  $clog2(GAME_H)  game y coordinate
- game_pix_stb  out  1  first physical pixel of each game pixel
- frame_stb  out  1  one cycle at game origin (sx==sy==0)
- display_enabled  out  1  beam inside game window
- rgb_in  in  12  {R,G,B} from game, valid PIPE_LAT cycles after matching sx/sy
- vga_r, vga_g, vga_b  out  4 each  pin colour
- vga_hs, vga_vs  out  1  syncs, active-low

Behaviour:
- Counters:
  - hcnt 0..H_TOTAL-1 (H_TOTAL = 800). Wraps to 0, then vcnt increments.
  - vcnt 0..V_TOTAL-1 (V_TOTAL = 525). Wraps to 0.
  - Frame = 420000 cycles at defaults.
- Window: in_win = hcnt in [X_OFF, X_OFF+GAME_W*SCALE) and vcnt in [Y_OFF, Y_OFF+GAME_H*SCALE).
- Sub-counters:
  - sub_x clears at hcnt==X_OFF and counts modulo SCALE.
  - sub_y clears at vcnt==Y_OFF and advances at each line end while in window rows.
- Registered outputs, latency 1 from the counters:
  - sx = (hcnt-X_OFF)/SCALE and sy = (vcnt-Y_OFF)/SCALE when in_win; both 0 otherwise. No divider: increment on sub-counter wrap.
  - display_enabled = in_win.
  - game_pix_stb = in_win & sub_x==0.
  - frame_stb = hcnt==X_OFF & vcnt==Y_OFF. Exactly one pulse per frame.
- Raw syncs:
  - hs_raw low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vs_raw low for vcnt in [V_ACTIVE+V_FP, ...+V_SYNC), i.e. 490..491.
  - Both registered alongside sx.
- Sync alignment:
  - hs, vs and display_enabled pass through a PIPE_LAT-deep delay line.
  - Output register: vga_* = de_d ? rgb_in : 0. vga_hs/vga_vs take the delayed syncs.
  - Total counter-to-pin latency = PIPE_LAT+2, with RGB and syncs aligned.
- Reset (rst_n low, any time including mid-line):
  - Counters, sub-counters, sx, sy and all strobes go to 0.
  - display_enabled = 0, vga_rgb = 0, vga_hs = vga_vs = 1.
  - Delay-line stages take inactive values (sync 1, de 0).
- After release: the first active edge sees hcnt=vcnt=0. No partial frame_stb is issued before the first window origin.
- Elaboration errors:
  - X_OFF+GAME_W*SCALE > H_ACTIVE
  - Y_OFF+GAME_H*SCALE > V_ACTIVE
  - SCALE == 0
- Boundaries:
  - Last window pixel: sx=GAME_W-1, and the next cycle display_enabled=0, sx=0.
  - Last line: hcnt and vcnt wrap in the same cycle.

Decomposition:
- Timing constants, H_TOTAL/V_TOTAL derivation and default window offsets live in params::vga. Game dimensions stay in params::pacman.
- One sub-module: sync_delay. Parameters DEPTH, WIDTH, RST_VAL; asynchronous active-low reset shift register. Used for the {hs, vs, de} alignment.

Test Plan:
- Reset mid-frame: assert rst_n=0 at hcnt=300, vcnt=200 -> all outputs at reset values the same cycle. After release, first hsync low edge at pin exactly 656+PIPE_LAT+2 cycles later.
- Line timing: free-run 3 lines -> vga_hs low for 96 cycles, period 800. vga_vs low for 1600 cycles, period 420000.
- frame_stb: run 2 frames -> exactly 2 pulses, 420000 cycles apart. sx=0, sy=0 on pulse cycle, i.e. 1 cycle after hcnt=208, vcnt=96.
- Window edges: at hcnt=431, vcnt=383 -> next cycle sx=223, sy=287, display_enabled=1. At hcnt=432 -> display_enabled=0, sx=0.
- SCALE=2, H_ACTIVE=800, V_ACTIVE=600, X_OFF=176, Y_OFF=12 -> game_pix_stb every 2nd cycle. sx steps 0,0,1,1…223,223. sy changes every 2 lines.
- Blanking: rgb_in held 12'hFFF -> pins FFF only during delayed window (448 cycles of 800 at SCALE=2 on window lines; 224 at SCALE=1), else 000. First FFF pixel aligned PIPE_LAT+2 after hcnt=X_OFF.
